// File: rtl/jtopl_eg_run_if.sv
// Signal bundle between the OPL envelope control logic and the envelope run stage.
// The control logic is the master; the run stage is the slave.
interface jtopl_eg_run_if;
   logic       cen;
   logic       tick;
   logic       keyon;
   logic       ksr;
   logic [3:0] kcode;
   logic [5:0] tl;
   logic [2:0] state_next;
   logic [4:0] base_rate;
   logic       keyon_now;
   logic       keyoff_now;
   logic [2:0] state_q;
   logic [9:0] eg_q;
   logic [9:0] eg_out;

   modport master (
      output cen, tick, keyon, ksr, kcode, tl, state_next, base_rate,
      input  keyon_now, keyoff_now, state_q, eg_q, eg_out
   );

   modport slave (
      input  cen, tick, keyon, ksr, kcode, tl, state_next, base_rate,
      output keyon_now, keyoff_now, state_q, eg_q, eg_out
   );
endinterface

// File: rtl/jtopl_eg_run.sv
// Sequential half of the OPL envelope generator: global counter, rate stepping,
// attenuation register, key edge detection and total-level output stage.
module jtopl_eg_run #(
   parameter int CNT_W = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   jtopl_eg_run_if.slave  bus
);

   localparam logic [2:0] ST_ATTACK  = 3'b001;
   localparam logic [2:0] ST_RELEASE = 3'b000;
   localparam logic [9:0] EG_MAX     = 10'h3FF;

   logic             keyon_last_q, keyon_last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       state_q, state_d;
   logic [9:0]       eg_q, eg_d;
   logic [9:0]       eg_out_q, eg_out_d;

   logic             upd;
   logic [3:0]       rof;
   logic [6:0]       rate_sum;
   logic [5:0]       rate;
   logic [3:0]       rh;
   logic [1:0]       rl;
   logic [7:0]       pat_bits;
   logic [3:0]       sh;
   logic [CNT_W-1:0] low_mask;
   logic [CNT_W-1:0] cnt_sh;
   logic [2:0]       inc;
   logic [12:0]      prod;
   logic [9:0]       dec;
   logic [10:0]      up_sum;
   logic [10:0]      out_sum;

   function automatic logic [7:0] step_pattern(input logic [1:0] sel);
      case (sel)
         2'd0:    step_pattern = 8'b10101010;
         2'd1:    step_pattern = 8'b11101010;
         2'd2:    step_pattern = 8'b11101110;
         default: step_pattern = 8'b11111110;
      endcase
   endfunction

   assign upd = bus.cen & bus.tick;

   // Key-scaled rate, clamped to 63; a zero base rate freezes the envelope.
   assign rof      = bus.ksr ? bus.kcode : {2'b00, bus.kcode[3:2]};
   assign rate_sum = {1'b0, bus.base_rate, 1'b0} + {3'b000, rof};
   assign rate     = (bus.base_rate == 5'd0) ? 6'd0 :
                     (rate_sum > 7'd63)      ? 6'd63 : rate_sum[5:0];
   assign rh       = rate[5:2];
   assign rl       = rate[1:0];
   assign pat_bits = step_pattern(rl);

   assign sh       = 4'd13 - rh;
   assign low_mask = ({{(CNT_W-1){1'b0}}, 1'b1} << sh) - {{(CNT_W-1){1'b0}}, 1'b1};
   assign cnt_sh   = cnt_q >> sh;

   always_comb begin
      inc = 3'd0;
      case (rh)
         4'd0:  inc = 3'd0;
         4'd13: inc = pat_bits[cnt_q[2:0]] ? 3'd2 : 3'd1;
         4'd14: inc = pat_bits[cnt_q[2:0]] ? 3'd4 : 3'd2;
         4'd15: inc = 3'd4;
         default: begin
            if (((cnt_q & low_mask) == '0) && pat_bits[cnt_sh[2:0]])
               inc = 3'd1;
         end
      endcase
   end

   // Attack shrinks towards zero exponentially; every other state counts up linearly.
   assign prod   = {3'b000, eg_q} * {10'b0, inc};
   assign dec    = prod[12:3] + 10'd1;
   assign up_sum = {1'b0, eg_q} + {8'b0, inc};

   always_comb begin
      eg_d = eg_q;
      if (upd) begin
         if (bus.state_next == ST_ATTACK) begin
            if (rate >= 6'd62)
               eg_d = 10'd0;
            else if (inc != 3'd0)
               eg_d = (eg_q <= dec) ? 10'd0 : eg_q - dec;
         end else if (inc != 3'd0) begin
            eg_d = up_sum[10] ? EG_MAX : up_sum[9:0];
         end
      end
   end

   assign out_sum      = {1'b0, eg_q} + {3'b000, bus.tl, 2'b00};
   assign eg_out_d     = bus.cen ? (out_sum[10] ? EG_MAX : out_sum[9:0]) : eg_out_q;
   assign cnt_d        = upd ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
   assign keyon_last_d = upd ? bus.keyon : keyon_last_q;
   assign state_d      = upd ? bus.state_next : state_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         keyon_last_q <= 1'b0;
         cnt_q        <= '0;
         state_q      <= ST_RELEASE;
         eg_q         <= EG_MAX;
         eg_out_q     <= EG_MAX;
      end else begin
         keyon_last_q <= keyon_last_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         eg_q         <= eg_d;
         eg_out_q     <= eg_out_d;
      end
   end

   assign bus.keyon_now  = bus.keyon & ~keyon_last_q;
   assign bus.keyoff_now = ~bus.keyon & keyon_last_q;
   assign bus.state_q    = state_q;
   assign bus.eg_q       = eg_q;
   assign bus.eg_out     = eg_out_q;

endmodule

// File: tb/tb_jtopl_eg_run.sv
// Self-checking bench for jtopl_eg_run: directed scenarios plus randomized traffic
// compared against an arithmetic envelope model.
module tb_jtopl_eg_run;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   int m_cnt, m_eg, m_state, m_kl, m_out;

   jtopl_eg_run_if bus ();

   jtopl_eg_run #(.CNT_W(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic int m_rate(int br, int ks, int kc);
      int r;
      if (br == 0) return 0;
      r = 2 * br + (ks != 0 ? kc : kc / 4);
      return (r > 63) ? 63 : r;
   endfunction

   function automatic int m_inc(int rate, int cnt);
      int pat[4] = '{170, 234, 238, 254};
      int rh, rl, sh, bitv;
      rh = rate / 4;
      rl = rate % 4;
      if (rh == 0) return 0;
      if (rh == 15) return 4;
      if (rh >= 13) begin
         bitv = (pat[rl] >> (cnt % 8)) & 1;
         return (rh == 13) ? 1 + bitv : 2 * (1 + bitv);
      end
      sh = 13 - rh;
      bitv = (pat[rl] >> ((cnt / (1 << sh)) % 8)) & 1;
      return ((cnt % (1 << sh)) == 0 && bitv == 1) ? 1 : 0;
   endfunction

   // Advance the reference model with the inputs present before the edge, then clock.
   task automatic step();
      int rate, inc, d, n_eg, n_out;
      if (!rst_n) begin
         m_kl = 0; m_cnt = 0; m_state = 0; m_eg = 1023; m_out = 1023;
      end else if (bus.cen) begin
         n_out = m_eg + 4 * int'(bus.tl);
         if (n_out > 1023) n_out = 1023;
         if (bus.tick) begin
            rate = m_rate(int'(bus.base_rate), int'(bus.ksr), int'(bus.kcode));
            inc  = m_inc(rate, m_cnt);
            n_eg = m_eg;
            if (bus.state_next == 3'b001) begin
               if (rate >= 62) n_eg = 0;
               else if (inc > 0) begin
                  d = (m_eg * inc) / 8 + 1;
                  n_eg = (m_eg <= d) ? 0 : m_eg - d;
               end
            end else if (inc > 0) begin
               n_eg = (m_eg + inc > 1023) ? 1023 : m_eg + inc;
            end
            m_kl = int'(bus.keyon);
            m_cnt = (m_cnt + 1) % 32768;
            m_state = int'(bus.state_next);
            m_eg = n_eg;
         end
         m_out = n_out;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.cen = 1'b1; bus.tick = 1'b0; bus.keyon = 1'b1; bus.ksr = 1'b0;
      bus.kcode = 4'h0; bus.tl = 6'h00; bus.state_next = 3'b000; bus.base_rate = 5'd0;
      step();
      step();
      vectors++; if (bus.state_q !== 3'b000) begin miscompares++; $display("FAIL reset_state got %h want 000", bus.state_q); end
      vectors++; if (bus.eg_q !== 10'h3FF) begin miscompares++; $display("FAIL reset_eg got %h want 3ff", bus.eg_q); end
      vectors++; if (bus.eg_out !== 10'h3FF) begin miscompares++; $display("FAIL reset_egout got %h want 3ff", bus.eg_out); end
      vectors++; if (bus.keyon_now !== 1'b1) begin miscompares++; $display("FAIL reset_keyon_now got %b want 1", bus.keyon_now); end
      rst_n = 1'b1;
      step();
      vectors++; if (bus.keyon_now !== 1'b1) begin miscompares++; $display("FAIL keyon_held_noupd got %b want 1", bus.keyon_now); end
      bus.tick = 1'b1;
      step();
      vectors++; if (bus.keyon_now !== 1'b0) begin miscompares++; $display("FAIL keyon_consumed got %b want 0", bus.keyon_now); end
      vectors++; if (bus.eg_q !== 10'h3FF) begin miscompares++; $display("FAIL frozen_eg got %h want 3ff", bus.eg_q); end
   endtask

   task automatic test_attack();
      int exp_eg[10] = '{511, 255, 127, 63, 31, 15, 7, 3, 1, 0};
      bus.state_next = 3'b001; bus.base_rate = 5'd30; bus.ksr = 1'b0; bus.kcode = 4'h0;
      bus.cen = 1'b1; bus.tick = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         vectors++; if (bus.eg_q !== 10'(exp_eg[i])) begin miscompares++; $display("FAIL attack_step%0d got %0d want %0d", i, bus.eg_q, exp_eg[i]); end
         vectors++; if (bus.eg_out !== 10'(m_out)) begin miscompares++; $display("FAIL attack_egout%0d got %0d want %0d", i, bus.eg_out, m_out); end
      end
      vectors++; if (bus.state_q !== 3'b001) begin miscompares++; $display("FAIL attack_state got %h want 001", bus.state_q); end
   endtask

   task automatic test_instant_attack();
      rst_n = 1'b0; bus.tick = 1'b0;
      step();
      rst_n = 1'b1;
      bus.state_next = 3'b001; bus.base_rate = 5'd30; bus.ksr = 1'b1; bus.kcode = 4'hF; bus.tick = 1'b1;
      step();
      vectors++; if (bus.eg_q !== 10'd0) begin miscompares++; $display("FAIL instant_attack got %h want 000", bus.eg_q); end
      for (int i = 0; i < 15; i++) begin
         step();
         vectors++; if (bus.eg_q !== 10'(m_eg)) begin miscompares++; $display("FAIL instant_hold%0d got %h want %h", i, bus.eg_q, m_eg); end
      end
   endtask

   task automatic test_decay();
      int exp_eg = 0;
      bus.state_next = 3'b010; bus.base_rate = 5'd24; bus.ksr = 1'b0; bus.kcode = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if ((i % 4) == 2) exp_eg++;
         step();
         vectors++; if (bus.eg_q !== 10'(exp_eg)) begin miscompares++; $display("FAIL decay_step%0d got %0d want %0d", i, bus.eg_q, exp_eg); end
      end
      vectors++; if (bus.eg_q !== 10'd4) begin miscompares++; $display("FAIL decay_final got %0d want 4", bus.eg_q); end
   endtask

   task automatic test_release_sat();
      int guard = 0;
      bus.state_next = 3'b000; bus.base_rate = 5'd31; bus.ksr = 1'b1; bus.kcode = 4'hF;
      while (m_eg != 1020 && guard < 400) begin
         step(); guard++;
         vectors++; if (bus.eg_q !== 10'(m_eg)) begin miscompares++; $display("FAIL release_ramp got %h want %h", bus.eg_q, m_eg); end
      end
      bus.base_rate = 5'd24; bus.ksr = 1'b0; bus.kcode = 4'h0; guard = 0;
      while (m_eg != 1022 && guard < 64) begin
         step(); guard++;
      end
      vectors++; if (bus.eg_q !== 10'h3FE) begin miscompares++; $display("FAIL release_setup got %h want 3fe", bus.eg_q); end
      bus.base_rate = 5'd31; bus.ksr = 1'b1; bus.kcode = 4'hF;
      step();
      vectors++; if (bus.eg_q !== 10'h3FF) begin miscompares++; $display("FAIL release_sat got %h want 3ff", bus.eg_q); end
      step();
      vectors++; if (bus.eg_q !== 10'h3FF) begin miscompares++; $display("FAIL release_stay got %h want 3ff", bus.eg_q); end
      bus.tl = 6'h3F; bus.tick = 1'b0;
      step();
      vectors++; if (bus.eg_out !== 10'h3FF) begin miscompares++; $display("FAIL tl_sat got %h want 3ff", bus.eg_out); end
      bus.tl = 6'h00;
   endtask

   task automatic test_gating();
      bus.cen = 1'b1; bus.tick = 1'b1;
      bus.state_next = 3'b001; bus.base_rate = 5'd30; bus.ksr = 1'b1; bus.kcode = 4'hF;
      step();
      bus.tick = 1'b0;
      step();
      vectors++; if (bus.eg_out !== 10'd0) begin miscompares++; $display("FAIL gate_pre_egout got %h want 000", bus.eg_out); end
      bus.cen = 1'b0; bus.tick = 1'b1; bus.state_next = 3'b000; bus.base_rate = 5'd31; bus.tl = 6'h10;
      for (int i = 0; i < 3; i++) step();
      vectors++; if (bus.eg_q !== 10'd0) begin miscompares++; $display("FAIL gate_eg got %h want 000", bus.eg_q); end
      vectors++; if (bus.state_q !== 3'b001) begin miscompares++; $display("FAIL gate_state got %h want 001", bus.state_q); end
      vectors++; if (bus.eg_out !== 10'd0) begin miscompares++; $display("FAIL gate_egout got %h want 000", bus.eg_out); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      vectors++; if (bus.state_q !== 3'b000) begin miscompares++; $display("FAIL gate_rst_state got %h want 000", bus.state_q); end
      vectors++; if (bus.eg_q !== 10'h3FF) begin miscompares++; $display("FAIL gate_rst_eg got %h want 3ff", bus.eg_q); end
      vectors++; if (bus.eg_out !== 10'h3FF) begin miscompares++; $display("FAIL gate_rst_egout got %h want 3ff", bus.eg_out); end
      vectors++; if (bus.keyon_now !== bus.keyon) begin miscompares++; $display("FAIL gate_rst_keyon_now got %b want %b", bus.keyon_now, bus.keyon); end
      bus.tl = 6'h00;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst_n = (($urandom % 64) != 0);
         bus.cen = (($urandom % 4) != 0);
         bus.tick = $urandom % 2;
         if (($urandom % 8) == 0) bus.keyon = ~bus.keyon;
         bus.ksr = $urandom % 2;
         bus.kcode = 4'($urandom);
         bus.tl = 6'($urandom % 16);
         bus.state_next = 3'($urandom);
         bus.base_rate = 5'($urandom);
         step();
         vectors++; if (bus.eg_q !== 10'(m_eg)) begin miscompares++; $display("FAIL rand_eg cyc%0d got %h want %h", i, bus.eg_q, m_eg); end
         vectors++; if (bus.eg_out !== 10'(m_out)) begin miscompares++; $display("FAIL rand_egout cyc%0d got %h want %h", i, bus.eg_out, m_out); end
         vectors++; if (bus.state_q !== 3'(m_state)) begin miscompares++; $display("FAIL rand_state cyc%0d got %h want %h", i, bus.state_q, m_state); end
         vectors++; if (bus.keyon_now !== (bus.keyon && m_kl == 0)) begin miscompares++; $display("FAIL rand_keyon_now cyc%0d got %b want %b", i, bus.keyon_now, (bus.keyon && m_kl == 0)); end
         vectors++; if (bus.keyoff_now !== (!bus.keyon && m_kl == 1)) begin miscompares++; $display("FAIL rand_keyoff_now cyc%0d got %b want %b", i, bus.keyoff_now, (!bus.keyon && m_kl == 1)); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.cen = 1'b0; bus.tick = 1'b0; bus.keyon = 1'b0; bus.ksr = 1'b0;
      bus.kcode = 4'h0; bus.tl = 6'h00; bus.state_next = 3'b000; bus.base_rate = 5'd0;
      m_cnt = 0; m_eg = 1023; m_state = 0; m_kl = 0; m_out = 1023;
      test_reset();
      test_attack();
      test_instant_attack();
      test_decay();
      test_release_sat();
      test_gating();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/jtopl_eg_run.md
Name: jtopl_eg_run

Overview:
Sequential half of the OPL envelope generator for one operator.
- Upstream: the envelope control logic supplies state_next and base_rate.
- This block registers envelope state and attenuation (eg_q), runs the global envelope counter, applies key-scaled rate stepping, and produces key edges plus the final TL-added attenuation.
- state_q, eg_q, keyon_now and keyoff_now feed back to the control logic.

Parameters:
CNT_W, 15, global envelope counter width (minimum 15)

Ports:
clk        in   1   system clock
rst_n      in   1   synchronous, active-low reset
cen        in   1   clock enable; all non-reset register updates are gated by it
tick       in   1   envelope sample strobe; qualified by cen
keyon      in   1   key-on level from register file
ksr        in   1   key-scale-rate enable
kcode      in   4   key code {block, fnum msb}
tl         in   6   total level
state_next in   3   next state from control (ATTACK=001, DECAY=010, HOLD=100, RELEASE=000)
base_rate  in   5   rate from control; 0 means frozen
keyon_now  out  1   combinational: keyon & ~keyon_last
keyoff_now out  1   combinational: ~keyon & keyon_last
state_q    out  3   registered envelope state
eg_q       out  10  registered attenuation; 0 = loudest, 0x3FF = silent
eg_out     out  10  registered saturated eg_q + {tl,2'b00}

Behaviour:
- Reset (rst_n=0 at clk edge, regardless of cen) sets:
  - keyon_last=0, cnt=0, state_q=000, eg_q=0x3FF, eg_out=0x3FF.
- Update qualifier: upd = cen & tick. With upd=0, cnt, keyon_last, state_q and eg_q hold.
- Key edges: keyon_last<=keyon on upd only. An edge therefore stays asserted until the next upd consumes it.
- Counter: cnt<=cnt+1 on upd, wrapping at 2^CNT_W. Step decisions use the pre-increment value.
- Rate computation (combinational):
  - rof = ksr ? kcode : {2'b00, kcode[3:2]}.
  - rate = (base_rate==0) ? 0 : min(63, {base_rate,1'b0}+rof), evaluated in 7 bits.
  - rh = rate[5:2], rl = rate[1:0].
- Pattern table pat[rl], 8 bits: 0:8'b10101010, 1:8'b11101010, 2:8'b11101110, 3:8'b11111110.
- Increment inc (0..4):
  - rh==0: inc=0.
  - rh 1..12: sh=13-rh; inc=1 when cnt[sh-1:0]==0 and pat[rl][cnt[sh+2:sh]]==1, else 0.
  - rh==13: inc=1+pat[rl][cnt[2:0]].
  - rh==14: inc=2*(1+pat[rl][cnt[2:0]]).
  - rh==15: inc=4.
- Attenuation update on upd. Direction is chosen by state_next:
  - ATTACK with rate>=62: eg_q<=0.
  - ATTACK otherwise, inc>0: d=((eg_q*inc)>>3)+1; eg_q<= (eg_q<=d) ? 0 : eg_q-d.
  - DECAY/HOLD/RELEASE: eg_q<=min(0x3FF, eg_q+inc).
  - inc==0: eg_q holds.
- State: state_q<=state_next on upd. Key-on never resets eg_q; attack starts from the current level.
- eg_out <= min(0x3FF, eg_q+{tl,2'b00}) on every cen cycle, using the current registered eg_q.
  - Latency: one cen cycle after eg_q changes.
- Simultaneous events:
  - keyon and keyoff edges are mutually exclusive by construction.
  - A keyon edge arriving in the same cycle as upd is consumed by that upd.
  - Reset wins over cen and tick.
- Reset mid-envelope returns to RELEASE/0x3FF immediately. The edge history is cleared, so a held keyon re-triggers keyon_now.
- Unknown state_next codes are treated as RELEASE (increment direction).

Test Plan:
1. Reset with keyon=1 held -> state_q=000, eg_q=0x3FF, eg_out=0x3FF, keyon_now=1 until the first upd, then 0.
2. Attack: drive state_next=001, base_rate=5'd30, ksr=0, kcode=0 (rate 60, inc=4), eg_q=0x3FF. Successive upds -> eg_q = 511, 255, 127, 63, 31, 15, 7, 3, 1, 0.
3. Instant attack: base_rate=5'd30, ksr=1, kcode=4'hF (rate 63) -> eg_q=0 on the first upd.
4. Decay: state_next=010, base_rate=5'd24, kcode=0 (rate 48, rh=12, rl=0), cnt starting at 0, eg_q=0. After 16 upds -> eg_q=4, with increments at cnt=2, 6, 10, 14.
5. Release saturation: state_next=000, base_rate=5'd31, ksr=1, kcode=4'hF (rh=15, inc=4), eg_q=0x3FE -> eg_q=0x3FF and stays there. With tl=6'h3F -> eg_out=0x3FF.
6. Gating: pulse tick with cen=0 -> no change to cnt, eg_q or state_q. Assert rst_n=0 with cen=0 -> full reset values on the next clk edge.
